// File: rtl/apb_slave_mem.sv
// APB completer backed by a small word-addressed register memory, with
// programmable wait states, range-error response and saturating transfer counters.
module apb_slave_mem #(
    parameter int unsigned                APB_ADDR_WIDTH = 32,
    parameter int unsigned                APB_DATA_WIDTH = 32,
    parameter int unsigned                MEM_DEPTH      = 16,
    parameter logic [APB_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter int unsigned                WAIT_CYCLES    = 1
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic [APB_DATA_WIDTH-1:0] PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [15:0]               WR_CNT,
    output logic [15:0]               RD_CNT
);

    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned OFF_W  = APB_ADDR_WIDTH - 2;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                    state;
    logic [WAIT_W-1:0]         waitcnt;
    logic                      wr_q;
    logic                      err_q;
    logic [IDX_W-1:0]          idx_q;
    logic [APB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [OFF_W-1:0]          off_w;
    logic [IDX_W-1:0]          idx;
    logic                      err;

    // Word offset from the base; the two byte-lane bits of PADDR drop out here.
    assign off_w = OFF_W'((PADDR - BASE_ADDR) >> 2);
    assign idx   = off_w[IDX_W-1:0];
    assign err   = (PADDR < BASE_ADDR) || (|off_w[OFF_W-1:IDX_W]);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= IDLE;
            waitcnt <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            WR_CNT  <= '0;
            RD_CNT  <= '0;
            mem     <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    // Setup phase: capture the request; PENABLE alone is ignored.
                    if (PSEL && !PENABLE) begin
                        state   <= ACCESS;
                        wr_q    <= PWRITE;
                        err_q   <= err;
                        idx_q   <= idx;
                        waitcnt <= WAIT_W'(WAIT_CYCLES);
                        PRDATA  <= (PWRITE || err) ? '0 : mem[idx];
                        PREADY  <= (WAIT_CYCLES == 0);
                        PSLVERR <= (WAIT_CYCLES == 0) && err;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state   <= IDLE;
                        PRDATA  <= '0;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                    end else if (waitcnt != '0) begin
                        // PREADY rises together with the counter reaching zero.
                        waitcnt <= waitcnt - WAIT_W'(1);
                        PREADY  <= (waitcnt == WAIT_W'(1));
                        PSLVERR <= (waitcnt == WAIT_W'(1)) && err_q;
                    end else if (PENABLE) begin
                        state   <= IDLE;
                        PRDATA  <= '0;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        if (!err_q) begin
                            if (wr_q) begin
                                mem[idx_q] <= PWDATA;
                                if (WR_CNT != 16'hFFFF) WR_CNT <= WR_CNT + 16'd1;
                            end else begin
                                if (RD_CNT != 16'hFFFF) RD_CNT <= RD_CNT + 16'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem across four parameter sets
// (default, offset base, 3 wait states, 0 wait states).
module tb_apb_slave_mem;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    localparam logic [31:0] BASE  [4] = '{32'h0, 32'h100, 32'h0, 32'h0};
    localparam int          WAITC [4] = '{1, 1, 3, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  psel = 4'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;

    logic [31:0] prdata  [4];
    logic        pready  [4];
    logic        pslverr [4];
    logic [15:0] wr_cnt  [4];
    logic [15:0] rd_cnt  [4];

    logic [31:0] model  [4][16];
    logic [15:0] exp_wr [4];
    logic [15:0] exp_rd [4];
    exp_t        sb [$];
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    apb_slave_mem #(.BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_d0 (
        .ACLK(clk), .ARESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0]), .WR_CNT(wr_cnt[0]), .RD_CNT(rd_cnt[0]));
    apb_slave_mem #(.BASE_ADDR(32'h100), .WAIT_CYCLES(1)) u_d1 (
        .ACLK(clk), .ARESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1]), .WR_CNT(wr_cnt[1]), .RD_CNT(rd_cnt[1]));
    apb_slave_mem #(.BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_d2 (
        .ACLK(clk), .ARESET(rst), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
        .PSLVERR(pslverr[2]), .WR_CNT(wr_cnt[2]), .RD_CNT(rd_cnt[2]));
    apb_slave_mem #(.BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_d3 (
        .ACLK(clk), .ARESET(rst), .PSEL(psel[3]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[3]), .PREADY(pready[3]),
        .PSLVERR(pslverr[3]), .WR_CNT(wr_cnt[3]), .RD_CNT(rd_cnt[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            exp_wr[i] = '0;
            exp_rd[i] = '0;
            for (int w = 0; w < 16; w++) model[i][w] = '0;
        end
    endtask

    task automatic go_idle();
        psel    = 4'b0;
        penable = 1'b0;
    endtask

    // One APB transfer; entered and left just after a rising edge, so calls chain back-to-back.
    task automatic xfer(input int i, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t        e;
        logic [31:0] off;
        bit          err;
        int          idx;
        int          cyc;
        bit          got;
        off     = addr - BASE[i];
        err     = (addr < BASE[i]) || (off[31:2] >= 30'd16);
        idx     = err ? 0 : int'(off[5:2]);
        e.inst  = i;
        e.err   = err;
        e.rdata = (wr || err) ? 32'h0 : model[i][idx];
        e.lat   = WAITC[i] + 2;
        sb.push_back(e);

        psel    = 4'b0;
        psel[i] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge clk);
        chk("setup_pready", 32'(pready[i]), 32'h0);
        @(posedge clk);
        #1;
        penable = 1'b1;
        paddr   = 32'hDEAD_BEE0;
        pwrite  = ~wr;
        cyc     = 2;
        got     = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (pready[i]) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk("ready_seen", 32'(got), 32'h1);
        e       = sb.pop_front();
        last_rd = prdata[e.inst];
        chk("prdata", prdata[e.inst], e.rdata);
        chk("pslverr", 32'(pslverr[e.inst]), 32'(e.err));
        chk("latency", 32'(cyc), 32'(e.lat));
        if (got && !err) begin
            if (wr) begin
                model[i][idx] = data;
                if (exp_wr[i] != 16'hFFFF) exp_wr[i] = exp_wr[i] + 16'd1;
            end else begin
                if (exp_rd[i] != 16'hFFFF) exp_rd[i] = exp_rd[i] + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        chk("wr_cnt", 32'(wr_cnt[i]), 32'(exp_wr[i]));
        chk("rd_cnt", 32'(rd_cnt[i]), 32'(exp_rd[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_prdata", prdata[0], 32'h0);
        chk("rst_pready", 32'(pready[0]), 32'h0);
        chk("rst_pslverr", 32'(pslverr[0]), 32'h0);

        // Reset mid-read: outputs clear immediately and memory returns to zero.
        xfer(0, 1'b1, 32'h0, 32'h11);
        psel    = 4'b0001;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(negedge clk);
        chk("mid_read_data", prdata[0], 32'h11);
        rst = 1'b1;
        #1;
        chk("async_prdata", prdata[0], 32'h0);
        chk("async_pready", 32'(pready[0]), 32'h0);
        chk("async_wr_cnt", 32'(wr_cnt[0]), 32'h0);
        clear_model();
        @(posedge clk);
        #1;
        go_idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        xfer(0, 1'b0, 32'h0, 32'h0);
        chk("read_after_rst", last_rd, 32'h0);
        go_idle();

        // Single write/read with an unaligned write address.
        xfer(0, 1'b1, 32'h09, 32'hABABCDCD);
        xfer(0, 1'b0, 32'h08, 32'h0);
        go_idle();
        chk("single_rd", last_rd, 32'hABABCDCD);
        chk("single_wr_cnt", 32'(wr_cnt[0]), 32'h1);
        chk("single_rd_cnt", 32'(rd_cnt[0]), 32'h2);

        // Back-to-back writes then reads with no idle cycles.
        for (int j = 0; j < 8; j++) xfer(0, 1'b1, 32'(j * 4), 32'(j + 1));
        for (int j = 0; j < 8; j++) xfer(0, 1'b0, 32'(j * 4), 32'h0);
        go_idle();
        chk("b2b_last_rd", last_rd, 32'h8);

        // Out-of-range accesses.
        xfer(0, 1'b1, 32'h40, 32'h5);
        xfer(0, 1'b0, 32'h40, 32'h0);
        xfer(0, 1'b0, 32'h00, 32'h0);
        go_idle();
        chk("oor_word0", last_rd, 32'h1);
        xfer(1, 1'b1, 32'hFC, 32'h7);
        xfer(1, 1'b1, 32'h100, 32'h77);
        xfer(1, 1'b0, 32'h100, 32'h0);
        xfer(1, 1'b0, 32'h140, 32'h0);
        go_idle();

        // Abort a 3-wait-state write in its second access cycle.
        psel    = 4'b0100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h04;
        pwdata  = 32'h55;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(negedge clk);
        chk("abort_pready1", 32'(pready[2]), 32'h0);
        @(posedge clk);
        #1;
        go_idle();
        @(negedge clk);
        chk("abort_pready2", 32'(pready[2]), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_pready3", 32'(pready[2]), 32'h0);
        chk("abort_wr_cnt", 32'(wr_cnt[2]), 32'h0);
        @(posedge clk);
        #1;
        xfer(2, 1'b0, 32'h04, 32'h0);
        chk("abort_mem", last_rd, 32'h0);
        xfer(2, 1'b1, 32'h04, 32'h66);
        xfer(2, 1'b0, 32'h04, 32'h0);
        go_idle();
        chk("w3_rd", last_rd, 32'h66);

        // Zero wait states, top word, and counter saturation.
        xfer(3, 1'b1, 32'h3C, 32'hCAFEF00D);
        xfer(3, 1'b0, 32'h3C, 32'h0);
        go_idle();
        chk("w0_rd", last_rd, 32'hCAFEF00D);
        force u_d3.WR_CNT = 16'hFFFE;
        #1;
        release u_d3.WR_CNT;
        exp_wr[3] = 16'hFFFE;
        #1;
        chk("preload_wr_cnt", 32'(wr_cnt[3]), 32'h0000FFFE);
        @(posedge clk);
        #1;
        xfer(3, 1'b1, 32'h00, 32'h1);
        xfer(3, 1'b1, 32'h04, 32'h2);
        go_idle();
        chk("sat_wr_cnt", 32'(wr_cnt[3]), 32'h0000FFFF);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer (slave) that terminates one PSELx line of the AXI-to-APB bridge and backs it with a small word-addressed register memory. It decodes the APB setup/access phases, inserts a programmable number of wait states via PREADY, returns read data, flags out-of-range accesses on PSLVERR, and keeps saturating transfer counters. It is the far end of the bridge's APB master port and serves as both a bench peripheral and a reusable on-chip register block.

## Interface

- APB_ADDR_WIDTH, 32, PADDR width.
- APB_DATA_WIDTH, 32, PWDATA/PRDATA width; must be 32.
- MEM_DEPTH, 16, number of 32-bit words; power of two, 2..256.
- BASE_ADDR, 32'h0, byte address of word 0.
- WAIT_CYCLES, 1, wait states per transfer, 0..15.
- ACLK  in  1  clock; all state updates on its rising edge.
- ARESET  in  1  reset; asynchronous, active-high.
- PSEL  in  1  select from the bridge (one of PSEL1..PSEL4).
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  APB_ADDR_WIDTH  byte address.
- PWDATA  in  APB_DATA_WIDTH  write data.
- PRDATA  out  APB_DATA_WIDTH  read data.
- PREADY  out  1  transfer-complete / wait-state control.
- PSLVERR  out  1  error response, valid only with PREADY.
- WR_CNT  out  16  successful writes, saturating.
- RD_CNT  out  16  successful reads, saturating.

## Operation

- FSM states: IDLE, ACCESS.
- IDLE: when PSEL=1 and PENABLE=0 (setup cycle), the block registers PWRITE, the word index and the range-error flag, loads the wait counter with WAIT_CYCLES, latches the read data mem[idx] (0 if error or write), and moves to ACCESS. PENABLE=1 in IDLE is ignored.
- ACCESS: if PSEL=0, abort to IDLE with no write and no counter change. If the wait counter is nonzero, decrement it. If it is zero and PENABLE=1, complete and go to IDLE.
- Address decode: off = PADDR − BASE_ADDR; idx = off[..:2]; PADDR[1:0] are ignored (0x09 maps to word 2). Error when PADDR < BASE_ADDR or idx ≥ MEM_DEPTH.
- Write commit: on the completion edge, if write and no error, mem[idx] ← PWDATA, which is sampled on that edge. There are no byte strobes.
- Counters: on a non-error completion, WR_CNT or RD_CNT increments; each holds at 16'hFFFF. Error and aborted transfers do not count.
- Memory contents reset to 0.

## Timing

- Reset values (asynchronous, immediate on ARESET=1): state IDLE, PREADY 0, PSLVERR 0, PRDATA 0, WR_CNT 0, RD_CNT 0, every mem word 0.
- Reset during ACCESS aborts the transfer with no write.
- PREADY = (state==ACCESS) && (waitcnt==0). It is decoded from registers only, with no combinational path from the APB inputs.
- PSLVERR = PREADY && err_q. PRDATA = latched read data while in ACCESS on a read, otherwise 0.
- Transfer length: setup cycle + (WAIT_CYCLES+1) access cycles = WAIT_CYCLES+2 cycles. The default gives 3 cycles, with PREADY high only in the 3rd.
- Back-to-back: a new setup is accepted in the IDLE cycle directly after completion, with no dead cycle.
- Read-after-write to the same word returns the new data, because the write commits on the completion edge before the next setup latches the read.
- PADDR/PWRITE are captured at setup; later changes during ACCESS are ignored. PWDATA is used at completion.

## Test plan

- Reset: hold ARESET=1 mid-transfer, then release → all outputs 0 immediately, FSM IDLE. A read of 0x00 then returns PRDATA=0, PSLVERR=0.
- Single write/read: write 32'hABABCDCD to PADDR=0x09, then read 0x08 → PREADY high only in cycle 3 of each transfer, PRDATA=32'hABABCDCD, PSLVERR=0, WR_CNT=1, RD_CNT=1.
- Back-to-back: 8 writes of data j+1 to 0x00,0x04..0x1C with no idle cycles, then 8 reads → each transfer takes 3 cycles, reads return 1..8, WR_CNT=8, RD_CNT=8.
- Out of range: write 5 to 0x40, then read 0x40 → PSLVERR=1 coincident with PREADY, PRDATA=0, word 0 unchanged, counters unchanged. Repeat with BASE_ADDR=0x100 and PADDR=0xFC → error.
- Abort, WAIT_CYCLES=3: drop PSEL in the 2nd ACCESS cycle of a write of 0x55 to 0x04 → PREADY never asserted, mem[1] unchanged, WR_CNT unchanged. The next write completes in 5 cycles.
- WAIT_CYCLES=0: write then read 0x3C → each transfer takes 2 cycles with PREADY in cycle 2. Preloading WR_CNT to 16'hFFFE via force, then two writes → WR_CNT=16'hFFFF held.
